// File: rtl/armv8_pipe_pkg.sv
// Shared pipeline definitions: hazard FSM encodings, the zero-register index and control bundle.
// No logic of its own; the only function is a pure combinational load-use compare.
// The names here are referenced by the hazard unit, its interface and any pipeline-stage models.
package armv8_pipe_pkg;

  // Hazard FSM states; encoding 3 is unused and always recovers to HZ_RUN
  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_STALL    = 2'd1,
    HZ_MEM_WAIT = 2'd2
  } hz_state_e;

  // X31 reads as zero, so writing it never creates a true dependency
  localparam logic [4:0] XZR_IDX = 5'd31;

  // Width of each performance counter
  localparam int unsigned HZ_PERF_W = 16;

  // Pipeline control bundle, MSB first in this field order
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_bubble;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic pipeline_freeze;
  } hz_ctl_t;

  // Free-running pipeline
  localparam hz_ctl_t CTL_RUN    = 7'b1100000;
  // Hold PC and IF/ID, insert a bubble into ID/EX
  localparam hz_ctl_t CTL_STALL  = 7'b0010000;
  // Squash the three younger stages, let the PC take the branch target
  localparam hz_ctl_t CTL_FLUSH  = 7'b1101110;
  // Whole pipeline held while data memory is busy
  localparam hz_ctl_t CTL_FREEZE = 7'b0000001;

  // A load in EX whose destination feeds either source of the instruction in ID
  function automatic logic load_use_hit(input logic       mem_read,
                                        input logic [4:0] rd,
                                        input logic [4:0] rn,
                                        input logic [4:0] rm);
    return mem_read && (rd != XZR_IDX) && ((rd == rn) || (rd == rm));
  endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Signal bundle between the pipeline datapath and the hazard control unit.
// Pure wiring, zero latency.
// No handshake: the hazard unit answers combinationally in the same cycle.
interface hazard_control_unit_if;
  import armv8_pipe_pkg::*;

  logic                 ID_EX_MemRead;
  logic [4:0]           ID_EX_RegisterRd;
  logic [4:0]           IF_ID_RegisterRn1;
  logic [4:0]           IF_ID_RegisterRm2;
  logic                 EX_MEM_BranchTaken;
  logic                 EX_MEM_MemAccess;
  logic                 dmem_ready;

  logic                 PC_Write;
  logic                 IF_ID_Write;
  logic                 ID_EX_Bubble;
  logic                 IF_ID_Flush;
  logic                 ID_EX_Flush;
  logic                 EX_MEM_Flush;
  logic                 Pipeline_Freeze;
  logic                 mem_error;
  logic [1:0]           state;
  logic [HZ_PERF_W-1:0] stall_cnt;
  logic [HZ_PERF_W-1:0] flush_cnt;
  logic [HZ_PERF_W-1:0] freeze_cnt;

  // Pipeline side: supplies hazard sources, consumes controls
  modport master (
    output ID_EX_MemRead, ID_EX_RegisterRd, IF_ID_RegisterRn1, IF_ID_RegisterRm2,
           EX_MEM_BranchTaken, EX_MEM_MemAccess, dmem_ready,
    input  PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
           Pipeline_Freeze, mem_error, state, stall_cnt, flush_cnt, freeze_cnt
  );

  // Hazard unit side
  modport slave (
    input  ID_EX_MemRead, ID_EX_RegisterRd, IF_ID_RegisterRn1, IF_ID_RegisterRm2,
           EX_MEM_BranchTaken, EX_MEM_MemAccess, dmem_ready,
    output PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
           Pipeline_Freeze, mem_error, state, stall_cnt, flush_cnt, freeze_cnt
  );

endinterface

// File: rtl/hazard_perf_counter.sv
// Saturating event counter: counts cycles with inc_i high, sticks at all-ones.
// Latency: count reflects an event one clock after it occurs.
// No backpressure; the counter never wraps.
module hazard_perf_counter #(
  parameter int unsigned W = 16
) (
  input  logic         CLK,
  input  logic         RESET_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Increment on each event unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register, cleared by reset
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use stalls, taken-branch flushes, data-memory freeze with timeout.
// Latency: controls are combinational from inputs and FSM state (same cycle); state advances per clock.
// Priority freeze > branch > load-use; optional perf counters when HAZARD_PERF_CNT_EN is defined.
module hazard_control_unit
  import armv8_pipe_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT       = 15
) (
  input logic                 CLK,
  input logic                 RESET_n,
  hazard_control_unit_if.slave hz
);

  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [8:0] TIMEOUT_LIM  = {1'b0, 8'(MEM_TIMEOUT)};

  hz_state_e  state_q, state_d;
  logic [2:0] stall_cnt_q, stall_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       flush_pending_q, flush_pending_d;
  logic       mem_error_q, mem_error_d;

  hz_ctl_t    ctl;
  hz_ctl_t    ctl_out;
  logic       freeze_hit;
  logic       branch_hit;
  logic       load_use;
  logic       wait_inc;

  assign freeze_hit = hz.EX_MEM_MemAccess && !hz.dmem_ready;
  assign branch_hit = hz.EX_MEM_BranchTaken;
  assign load_use   = load_use_hit(hz.ID_EX_MemRead, hz.ID_EX_RegisterRd,
                                   hz.IF_ID_RegisterRn1, hz.IF_ID_RegisterRm2);

  // Control decode and next-state selection for each FSM state
  always_comb begin
    ctl             = CTL_RUN;
    state_d         = state_q;
    stall_cnt_d     = stall_cnt_q;
    wait_cnt_d      = wait_cnt_q;
    flush_pending_d = flush_pending_q;
    mem_error_d     = mem_error_q;
    wait_inc        = 1'b0;

    case (state_q)
      HZ_RUN: begin
        if (freeze_hit) begin
          // A branch seen together with the freeze is deferred, not lost:
          // the frozen MEM stage still holds it, so it is flushed on release.
          ctl             = CTL_FREEZE;
          state_d         = HZ_MEM_WAIT;
          flush_pending_d = branch_hit;
          wait_inc        = 1'b1;
        end else if (branch_hit) begin
          ctl = CTL_FLUSH;
        end else if (load_use) begin
          ctl = CTL_STALL;
          if (LOAD_STALL_CYCLES > 1) begin
            stall_cnt_d = STALL_RELOAD;
            state_d     = HZ_STALL;
          end
        end
      end

      HZ_STALL: begin
        if (freeze_hit) begin
          // The stall is dropped; once memory completes, RUN re-detects the
          // load-use pair if it is still sitting in ID/EX.
          ctl             = CTL_FREEZE;
          state_d         = HZ_MEM_WAIT;
          stall_cnt_d     = '0;
          flush_pending_d = branch_hit;
          wait_inc        = 1'b1;
        end else if (branch_hit) begin
          ctl         = CTL_FLUSH;
          state_d     = HZ_RUN;
          stall_cnt_d = '0;
        end else begin
          ctl         = CTL_STALL;
          stall_cnt_d = stall_cnt_q - 3'd1;
          if (stall_cnt_q <= 3'd1) begin
            state_d = HZ_RUN;
          end
        end
      end

      HZ_MEM_WAIT: begin
        // Load-use detection is deliberately ignored while memory is busy
        if (hz.dmem_ready) begin
          ctl             = (flush_pending_q || branch_hit) ? CTL_FLUSH : CTL_RUN;
          state_d         = HZ_RUN;
          flush_pending_d = 1'b0;
          wait_cnt_d      = '0;
        end else begin
          ctl             = CTL_FREEZE;
          flush_pending_d = flush_pending_q || branch_hit;
          wait_inc        = 1'b1;
        end
      end

      default: begin
        state_d         = HZ_RUN;
        stall_cnt_d     = '0;
        wait_cnt_d      = '0;
        flush_pending_d = 1'b0;
      end
    endcase

    // mem_error rises at the edge that ends the MEM_TIMEOUT-th frozen cycle
    if (wait_inc) begin
      if (wait_cnt_q != 8'hFF) begin
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
      if (({1'b0, wait_cnt_q} + 9'd1) >= TIMEOUT_LIM) begin
        mem_error_d = 1'b1;
      end
    end
  end

  // FSM and bookkeeping registers; reset drops any pending flush and the error flag
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q         <= HZ_RUN;
      stall_cnt_q     <= '0;
      wait_cnt_q      <= '0;
      flush_pending_q <= 1'b0;
      mem_error_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      stall_cnt_q     <= stall_cnt_d;
      wait_cnt_q      <= wait_cnt_d;
      flush_pending_q <= flush_pending_d;
      mem_error_q     <= mem_error_d;
    end
  end

  // While reset is held the pipeline sees free-running controls regardless of inputs
  assign ctl_out = RESET_n ? ctl : CTL_RUN;

  assign hz.PC_Write        = ctl_out.pc_write;
  assign hz.IF_ID_Write     = ctl_out.if_id_write;
  assign hz.ID_EX_Bubble    = ctl_out.id_ex_bubble;
  assign hz.IF_ID_Flush     = ctl_out.if_id_flush;
  assign hz.ID_EX_Flush     = ctl_out.id_ex_flush;
  assign hz.EX_MEM_Flush    = ctl_out.ex_mem_flush;
  assign hz.Pipeline_Freeze = ctl_out.pipeline_freeze;
  assign hz.mem_error       = mem_error_q;
  assign hz.state           = state_q;

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_counter #(.W(HZ_PERF_W)) u_stall_cnt (
    .CLK     (CLK),
    .RESET_n (RESET_n),
    .inc_i   (ctl_out.id_ex_bubble),
    .cnt_o   (hz.stall_cnt)
  );

  hazard_perf_counter #(.W(HZ_PERF_W)) u_flush_cnt (
    .CLK     (CLK),
    .RESET_n (RESET_n),
    .inc_i   (ctl_out.if_id_flush),
    .cnt_o   (hz.flush_cnt)
  );

  hazard_perf_counter #(.W(HZ_PERF_W)) u_freeze_cnt (
    .CLK     (CLK),
    .RESET_n (RESET_n),
    .inc_i   (ctl_out.pipeline_freeze),
    .cnt_o   (hz.freeze_cnt)
  );
`else
  assign hz.stall_cnt  = '0;
  assign hz.flush_cnt  = '0;
  assign hz.freeze_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: one instance with single-cycle load stalls, one with three.
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
// Perf-counter expectations follow HAZARD_PERF_CNT_EN (zero when undefined).
module tb_hazard_control_unit;

  // Expected control vectors: {PC_Write, IF_ID_Write, Bubble, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, Freeze}
  localparam logic [6:0] C_RUN   = 7'b1100000;
  localparam logic [6:0] C_STALL = 7'b0010000;
  localparam logic [6:0] C_FLUSH = 7'b1101110;
  localparam logic [6:0] C_FRZ   = 7'b0000001;

  logic CLK = 1'b0;
  logic RESET_n;

  hazard_control_unit_if hz_a ();
  hazard_control_unit_if hz_b ();

  hazard_control_unit #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(15)) dut_a (
    .CLK     (CLK),
    .RESET_n (RESET_n),
    .hz      (hz_a)
  );

  hazard_control_unit #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(15)) dut_b (
    .CLK     (CLK),
    .RESET_n (RESET_n),
    .hz      (hz_b)
  );

  always #5 CLK = ~CLK;

  wire [6:0] ctl_a = {hz_a.PC_Write, hz_a.IF_ID_Write, hz_a.ID_EX_Bubble, hz_a.IF_ID_Flush,
                      hz_a.ID_EX_Flush, hz_a.EX_MEM_Flush, hz_a.Pipeline_Freeze};
  wire [6:0] ctl_b = {hz_b.PC_Write, hz_b.IF_ID_Write, hz_b.ID_EX_Bubble, hz_b.IF_ID_Flush,
                      hz_b.ID_EX_Flush, hz_b.EX_MEM_Flush, hz_b.Pipeline_Freeze};

  int checks = 0;
  int errors = 0;
  int exp_st_a = 0, exp_fl_a = 0, exp_fz_a = 0;
  int exp_st_b = 0, exp_fl_b = 0, exp_fz_b = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic mr, input logic [4:0] rd, input logic [4:0] rn,
                         input logic [4:0] rm, input logic br, input logic ma, input logic rdy);
    hz_a.ID_EX_MemRead      = mr;
    hz_a.ID_EX_RegisterRd   = rd;
    hz_a.IF_ID_RegisterRn1  = rn;
    hz_a.IF_ID_RegisterRm2  = rm;
    hz_a.EX_MEM_BranchTaken = br;
    hz_a.EX_MEM_MemAccess   = ma;
    hz_a.dmem_ready         = rdy;
  endtask

  task automatic drive_b(input logic mr, input logic [4:0] rd, input logic [4:0] rn,
                         input logic [4:0] rm, input logic br, input logic ma, input logic rdy);
    hz_b.ID_EX_MemRead      = mr;
    hz_b.ID_EX_RegisterRd   = rd;
    hz_b.IF_ID_RegisterRn1  = rn;
    hz_b.IF_ID_RegisterRm2  = rm;
    hz_b.EX_MEM_BranchTaken = br;
    hz_b.EX_MEM_MemAccess   = ma;
    hz_b.dmem_ready         = rdy;
  endtask

  // One clock cycle on instance A: check on the falling edge, then advance past the rising edge
  task automatic step_a(input string tag, input logic [6:0] ec, input logic [1:0] es, input logic ee);
    @(negedge CLK);
    chk({tag, "/ctl"}, 16'(ctl_a), 16'(ec));
    chk({tag, "/state"}, 16'(hz_a.state), 16'(es));
    chk({tag, "/mem_error"}, 16'(hz_a.mem_error), 16'(ee));
    exp_st_a += int'(ec[4]);
    exp_fl_a += int'(ec[3]);
    exp_fz_a += int'(ec[0]);
    @(posedge CLK);
    #1;
  endtask

  task automatic step_b(input string tag, input logic [6:0] ec, input logic [1:0] es);
    @(negedge CLK);
    chk({tag, "/ctl"}, 16'(ctl_b), 16'(ec));
    chk({tag, "/state"}, 16'(hz_b.state), 16'(es));
    exp_st_b += int'(ec[4]);
    exp_fl_b += int'(ec[3]);
    exp_fz_b += int'(ec[0]);
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_perf_a(input string tag);
    logic [15:0] es, ef, ez;
`ifdef HAZARD_PERF_CNT_EN
    es = 16'(exp_st_a); ef = 16'(exp_fl_a); ez = 16'(exp_fz_a);
`else
    es = 16'd0; ef = 16'd0; ez = 16'd0;
`endif
    chk({tag, "/stall_cnt"}, hz_a.stall_cnt, es);
    chk({tag, "/flush_cnt"}, hz_a.flush_cnt, ef);
    chk({tag, "/freeze_cnt"}, hz_a.freeze_cnt, ez);
  endtask

  task automatic chk_perf_b(input string tag);
    logic [15:0] es, ef, ez;
`ifdef HAZARD_PERF_CNT_EN
    es = 16'(exp_st_b); ef = 16'(exp_fl_b); ez = 16'(exp_fz_b);
`else
    es = 16'd0; ef = 16'd0; ez = 16'd0;
`endif
    chk({tag, "/stall_cnt"}, hz_b.stall_cnt, es);
    chk({tag, "/flush_cnt"}, hz_b.flush_cnt, ef);
    chk({tag, "/freeze_cnt"}, hz_b.freeze_cnt, ez);
  endtask

  initial begin
    // Reset held with a live load-use pair on the inputs: controls must still read RUN
    RESET_n = 1'b0;
    drive_a(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    drive_b(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    chk("rst_ctl_a", 16'(ctl_a), 16'(C_RUN));
    chk("rst_state_a", 16'(hz_a.state), 16'd0);
    chk("rst_err_a", 16'(hz_a.mem_error), 16'd0);
    chk("rst_ctl_b", 16'(ctl_b), 16'(C_RUN));
    chk_perf_a("rst_perf_a");
    #2;
    RESET_n = 1'b1;
    drive_a(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    drive_b(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

    step_a("idle", C_RUN, 2'd0, 1'b0);

    // Single-cycle load-use stall on Rn1, then on Rm2
    drive_a(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    step_a("lu_rn", C_STALL, 2'd0, 1'b0);
    drive_a(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step_a("lu_rn_after", C_RUN, 2'd0, 1'b0);
    drive_a(1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0);
    step_a("lu_rm", C_STALL, 2'd0, 1'b0);

    // No hazard: not a load, zero-register destination, or no source match
    drive_a(1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    step_a("no_load", C_RUN, 2'd0, 1'b0);
    drive_a(1'b1, 5'd31, 5'd31, 5'd31, 1'b0, 1'b0, 1'b0);
    step_a("xzr", C_RUN, 2'd0, 1'b0);
    drive_a(1'b1, 5'd5, 5'd6, 5'd9, 1'b0, 1'b0, 1'b0);
    step_a("no_match", C_RUN, 2'd0, 1'b0);

    // Branch beats load-use
    drive_a(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
    step_a("br_over_lu", C_FLUSH, 2'd0, 1'b0);

    // Freeze beats branch and load-use; the branch is flushed when memory completes
    drive_a(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0);
    step_a("frz_prio", C_FRZ, 2'd0, 1'b0);
    drive_a(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    step_a("frz_prio_rdy", C_FLUSH, 2'd2, 1'b0);
    drive_a(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step_a("frz_prio_done", C_RUN, 2'd0, 1'b0);

    // Four frozen cycles, branch in cycle 2 (load-use also present, must be ignored)
    drive_a(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    step_a("mw1", C_FRZ, 2'd0, 1'b0);
    drive_a(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0);
    step_a("mw2", C_FRZ, 2'd2, 1'b0);
    drive_a(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    step_a("mw3", C_FRZ, 2'd2, 1'b0);
    step_a("mw4", C_FRZ, 2'd2, 1'b0);
    drive_a(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    step_a("mw_rdy", C_FLUSH, 2'd2, 1'b0);
    drive_a(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step_a("mw_done", C_RUN, 2'd0, 1'b0);
    chk_perf_a("perf_a_mid");

    // Twenty cycles without ready: error visible after the 15th frozen cycle and sticky
    for (int i = 1; i <= 20; i++) begin
      drive_a(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      step_a($sformatf("to%0d", i), C_FRZ, (i == 1) ? 2'd0 : 2'd2, (i >= 16));
    end
    drive_a(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    step_a("to_rdy", C_RUN, 2'd2, 1'b1);
    drive_a(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step_a("to_held", C_RUN, 2'd0, 1'b1);
    chk_perf_a("perf_a_to");

    // Three-cycle load stall, then a branch aborting it in its second cycle
    drive_b(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    step_b("b_lu1", C_STALL, 2'd0);
    step_b("b_lu2", C_STALL, 2'd1);
    step_b("b_lu3", C_STALL, 2'd1);
    drive_b(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step_b("b_run", C_RUN, 2'd0);
    drive_b(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    step_b("b_br1", C_STALL, 2'd0);
    drive_b(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
    step_b("b_br2", C_FLUSH, 2'd1);
    drive_b(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step_b("b_br3", C_RUN, 2'd0);
    chk_perf_b("perf_b");

    // Reset in the middle of a freeze with a pending flush
    drive_a(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    step_a("rs1", C_FRZ, 2'd0, 1'b1);
    drive_a(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    step_a("rs2", C_FRZ, 2'd2, 1'b1);
    drive_a(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    #2;
    RESET_n = 1'b0;
    exp_st_a = 0; exp_fl_a = 0; exp_fz_a = 0;
    #1;
    chk("rs_ctl", 16'(ctl_a), 16'(C_RUN));
    chk("rs_state", 16'(hz_a.state), 16'd0);
    chk("rs_err", 16'(hz_a.mem_error), 16'd0);
    @(negedge CLK);
    RESET_n = 1'b1;
    drive_a(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    step_a("rs_rel1", C_RUN, 2'd0, 1'b0);
    step_a("rs_rel2", C_RUN, 2'd0, 1'b0);
    chk_perf_a("perf_a_rs");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
